// File: rtl/sc_backg_pkg.sv
// Shared types and helpers for the background-type lane bank.
package sc_backg_pkg;

  // Widest lane the rotate helpers support.
  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Mask with the low w bits set; w == MAX_W wraps to all ones.
  function automatic logic [MAX_W-1:0] low_mask(input int unsigned w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  // Rotate the low w bits of v toward the MSB; bits above w must be zero.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v, input int unsigned w);
    return ((v << 1) | (v >> (w - 1))) & low_mask(w);
  endfunction

  // Rotate the low w bits of v toward the LSB; bits above w must be zero.
  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] v, input int unsigned w);
    return ((v >> 1) | (v << (w - 1))) & low_mask(w);
  endfunction

  // Bit offset of entry [lvl][lane] in the flat level table.
  function automatic int unsigned table_offset(input int unsigned lvl, input int unsigned lane,
                                               input int unsigned lanes, input int unsigned dw);
    return (lvl * lanes + lane) * dw;
  endfunction

  // Bit offset of a lane's reload value in the flat speed table.
  function automatic int unsigned speed_offset(input int unsigned lane, input int unsigned per_w);
    return lane * per_w;
  endfunction

endpackage

// File: rtl/sc_backg_lane_bank_if.sv
// Control and data bundle between the level controller and the lane bank.
interface sc_backg_lane_bank_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned LVL_W     = 2
);
  logic                       clear_InLow;
  logic                       load_InLow;
  logic [LVL_W-1:0]           level_InBUS;
  logic                       loadfinal_InLow;
  logic [DATAWIDTH-1:0]       lastpoint_InBUS;
  logic                       tick_In;
  logic [LANES-1:0]           dir_InBUS;
  logic                       freeze_In;
  logic [LANES*DATAWIDTH-1:0] data_OutBUS;
  logic [LANES-1:0]           shift_pulse_OutBUS;
  logic                       running_Out;

  modport master (
    output clear_InLow, load_InLow, level_InBUS, loadfinal_InLow, lastpoint_InBUS,
    output tick_In, dir_InBUS, freeze_In,
    input  data_OutBUS, shift_pulse_OutBUS, running_Out
  );

  modport slave (
    input  clear_InLow, load_InLow, level_InBUS, loadfinal_InLow, lastpoint_InBUS,
    input  tick_In, dir_InBUS, freeze_In,
    output data_OutBUS, shift_pulse_OutBUS, running_Out
  );
endinterface

// File: rtl/sc_backg_lane.sv
// One playfield lane: pattern register, movement prescaler and rotate pulse.
module sc_backg_lane
  import sc_backg_pkg::*;
#(
  parameter int unsigned          DATAWIDTH    = 8,
  parameter int unsigned          PER_W        = 4,
  parameter logic [PER_W-1:0]     SPEED        = '0,
  parameter logic [DATAWIDTH-1:0] INIT_PATTERN = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 ld,
  input  logic [DATAWIDTH-1:0] ld_val,
  input  logic                 frz,
  input  logic                 merge,
  input  logic [DATAWIDTH-1:0] merge_val,
  input  logic                 step,
  input  logic                 dir,
  output logic [DATAWIDTH-1:0] data,
  output logic                 pulse
);

  logic [PER_W-1:0]     cnt;
  logic [DATAWIDTH-1:0] rot;

  // Candidate rotated value for this cycle's direction.
  always_comb begin
    rot = '0;
    if (dir) rot = DATAWIDTH'(rotr(MAX_W'(data), DATAWIDTH));
    else     rot = DATAWIDTH'(rotl(MAX_W'(data), DATAWIDTH));
  end

  // Lane state: clear > load > freeze > merge > prescaled rotate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (clr) begin
      data  <= INIT_PATTERN;
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (ld) begin
      data  <= ld_val;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (!frz) begin
        if (merge) begin
          // Prescaler deliberately holds while the last-point pattern merges in.
          data <= data | merge_val;
        end else if (step) begin
          if (cnt == SPEED) begin
            data  <= rot;
            cnt   <= '0;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + PER_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/sc_backg_lane_bank.sv
// Multi-lane background-type register bank with per-lane speed and direction.
module sc_backg_lane_bank
  import sc_backg_pkg::*;
#(
  parameter int unsigned                          DATAWIDTH    = 8,
  parameter int unsigned                          LANES        = 4,
  parameter int unsigned                          LEVELS       = 4,
  parameter int unsigned                          LVL_W        = 2,
  parameter int unsigned                          PER_W        = 4,
  parameter logic [DATAWIDTH-1:0]                 INIT_PATTERN = '0,
  parameter logic [LEVELS*LANES*DATAWIDTH-1:0]    LEVEL_TABLE  = '0,
  parameter logic [LANES*PER_W-1:0]               SPEED_TABLE  = '0
) (
  input logic              SC_LastRegBACKGTYPE_CLOCK_50,
  input logic              SC_LastRegBACKGTYPE_RESET_InHigh,
  sc_backg_lane_bank_if.slave bus
);

  state_e                     state_q;
  logic                       clr;
  logic                       ld;
  logic                       lf;
  logic                       step;
  logic [LVL_W-1:0]           lvl;
  logic [LANES*DATAWIDTH-1:0] data_flat;
  logic [LANES-1:0]           pulse_vec;

  // Control strobes arrive active-low.
  assign clr  = ~bus.clear_InLow;
  assign ld   = ~bus.load_InLow;
  assign lf   = ~bus.loadfinal_InLow;
  assign step = bus.tick_In & (state_q == RUN);

  // Mode FSM: load starts the playfield moving, clear parks it.
  always_ff @(posedge SC_LastRegBACKGTYPE_CLOCK_50 or posedge SC_LastRegBACKGTYPE_RESET_InHigh) begin
    if (SC_LastRegBACKGTYPE_RESET_InHigh) begin
      state_q <= EMPTY;
    end else if (clr) begin
      state_q <= EMPTY;
    end else if (ld) begin
      state_q <= RUN;
    end
  end

  // Out-of-range levels fall back to the last table entry.
  always_comb begin
    lvl = bus.level_InBUS;
    if (32'(bus.level_InBUS) > LEVELS - 1) lvl = LVL_W'(LEVELS - 1);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sc_backg_lane #(
      .DATAWIDTH    (DATAWIDTH),
      .PER_W        (PER_W),
      .SPEED        (SPEED_TABLE[speed_offset(i, PER_W) +: PER_W]),
      .INIT_PATTERN (INIT_PATTERN)
    ) u_lane (
      .clk       (SC_LastRegBACKGTYPE_CLOCK_50),
      .rst       (SC_LastRegBACKGTYPE_RESET_InHigh),
      .clr       (clr),
      .ld        (ld),
      .ld_val    (LEVEL_TABLE[table_offset(32'(lvl), i, LANES, DATAWIDTH) +: DATAWIDTH]),
      .frz       (bus.freeze_In),
      .merge     (lf && (i == LANES - 1)),
      .merge_val (bus.lastpoint_InBUS),
      .step      (step),
      .dir       (bus.dir_InBUS[i]),
      .data      (data_flat[i*DATAWIDTH +: DATAWIDTH]),
      .pulse     (pulse_vec[i])
    );
  end

  assign bus.data_OutBUS        = data_flat;
  assign bus.shift_pulse_OutBUS = pulse_vec;
  assign bus.running_Out        = (state_q == RUN);

endmodule
